// File: rtl/squash_unit_l2.sv
// squash_unit_l2: registered squash arbiter with a squash-suppression window.
// Each cycle the oldest valid squash channel is chosen. The age of a sequence
// number is its modular distance from the locally tracked in-flight head. The
// chosen squash is issued one cycle later unless an open window already covers it.
// Optional build macro SQUASH_UNIT_L2_STATS_EN adds the counters stat_issued
// and stat_filtered.
module squash_unit_l2 #(
    parameter int p_num_arb       = 4,
    parameter int p_seq_num_bits  = 5,
    parameter int p_window_cycles = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [p_num_arb*p_seq_num_bits-1:0]  arb_seq_num,
    input  logic [p_num_arb*32-1:0]              arb_target,
    input  logic [p_num_arb-1:0]                 arb_val,
    input  logic [p_seq_num_bits-1:0]            commit_seq_num,
    input  logic                                 commit_val,
`ifdef SQUASH_UNIT_L2_STATS_EN
    output logic [15:0]                          stat_issued,
    output logic [15:0]                          stat_filtered,
`endif
    output logic [p_seq_num_bits-1:0]            gnt_seq_num,
    output logic [31:0]                          gnt_target,
    output logic                                 gnt_val
);

    localparam int W = p_seq_num_bits;
    localparam logic [W-1:0] SEQ_ONE  = W'(1);
    localparam logic [7:0]   WIN_LOAD = 8'(p_window_cycles);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_WINDOW = 1'b1
    } win_state_e;

    win_state_e      state_q, state_d;
    logic [W-1:0]    head_q, head_d;
    logic [W-1:0]    win_seq_q, win_seq_d;
    logic [7:0]      win_cnt_q, win_cnt_d;
    logic            gnt_val_q, gnt_val_d;
    logic [W-1:0]    gnt_seq_q, gnt_seq_d;
    logic [31:0]     gnt_tgt_q, gnt_tgt_d;

    logic [W-1:0]    ch_seq [p_num_arb];
    logic [31:0]     ch_tgt [p_num_arb];
    logic [W-1:0]    ch_age [p_num_arb];

    logic            cand_found;
    logic [W-1:0]    cand_seq;
    logic [31:0]     cand_tgt;
    logic [W-1:0]    cand_age;
    logic [W-1:0]    win_age;
    logic            issue;

    // Unpack the channels and compute each channel's age relative to the registered head.
    for (genvar gi = 0; gi < p_num_arb; gi++) begin : g_ch
        assign ch_seq[gi] = arb_seq_num[gi*W +: W];
        assign ch_tgt[gi] = arb_target[gi*32 +: 32];
        assign ch_age[gi] = ch_seq[gi] - head_q;
    end

    // Oldest-valid selection. A strict less-than comparison keeps the lowest index on ties.
    always_comb begin
        cand_found = 1'b0;
        cand_seq   = '0;
        cand_tgt   = '0;
        cand_age   = '0;
        for (int i = 0; i < p_num_arb; i++) begin
            if (arb_val[i] && (!cand_found || ch_age[i] < cand_age)) begin
                cand_found = 1'b1;
                cand_seq   = ch_seq[i];
                cand_tgt   = ch_tgt[i];
                cand_age   = ch_age[i];
            end
        end
    end

    // Filter: an open window lets through only squashes strictly older than its seq num.
    assign win_age = win_seq_q - head_q;
    assign issue   = cand_found && ((state_q == ST_IDLE) || (cand_age < win_age));

    // Next-state logic for the window FSM, the head and the grant registers.
    always_comb begin
        state_d   = state_q;
        win_seq_d = win_seq_q;
        win_cnt_d = win_cnt_q;
        head_d    = commit_val ? (commit_seq_num + SEQ_ONE) : head_q;
        gnt_val_d = issue;
        gnt_seq_d = issue ? cand_seq : gnt_seq_q;
        gnt_tgt_d = issue ? cand_tgt : gnt_tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d   = ST_WINDOW;
                    win_seq_d = cand_seq;
                    win_cnt_d = WIN_LOAD;
                end
            end
            ST_WINDOW: begin
                // An issue takes priority over expiry or a closing commit in the same cycle.
                if (issue) begin
                    win_seq_d = cand_seq;
                    win_cnt_d = WIN_LOAD;
                end else if ((win_cnt_q == 8'd1) ||
                             (commit_val && (commit_seq_num == win_seq_q))) begin
                    state_d   = ST_IDLE;
                    win_cnt_d = 8'd0;
                end else begin
                    win_cnt_d = win_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                win_cnt_d = 8'd0;
            end
        endcase
    end

    // State register. Reset discards any open window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            head_q    <= '0;
            win_seq_q <= '0;
            win_cnt_q <= 8'd0;
            gnt_val_q <= 1'b0;
            gnt_seq_q <= '0;
            gnt_tgt_q <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            win_seq_q <= win_seq_d;
            win_cnt_q <= win_cnt_d;
            gnt_val_q <= gnt_val_d;
            gnt_seq_q <= gnt_seq_d;
            gnt_tgt_q <= gnt_tgt_d;
        end
    end

    assign gnt_val     = gnt_val_q;
    assign gnt_seq_num = gnt_seq_q;
    assign gnt_target  = gnt_tgt_q;

`ifdef SQUASH_UNIT_L2_STATS_EN
    logic [15:0] stat_issued_q;
    logic [15:0] stat_filtered_q;

    // Saturating counters: issued squashes and cycles in which a candidate was dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q   <= 16'd0;
            stat_filtered_q <= 16'd0;
        end else begin
            if (issue && (stat_issued_q != 16'hFFFF)) begin
                stat_issued_q <= stat_issued_q + 16'd1;
            end
            if (cand_found && !issue && (stat_filtered_q != 16'hFFFF)) begin
                stat_filtered_q <= stat_filtered_q + 16'd1;
            end
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_filtered = stat_filtered_q;
`endif

endmodule

// File: doc/squash_unit_l2.md
Name: squash_unit_l2

Overview:
- Registered, parametrised successor to the first-level squash arbiter.
- Selects the oldest valid squash notification among p_num_arb channels each cycle and registers it onto the grant notification.
- Holds a squash window after each issued squash, suppressing redundant squashes younger than the one already issued.
- Tracks the in-flight head from commit notifications, so age comparison is explicit and local to the block.

Parameters:
- p_num_arb, 4, number of squash channels; legal range 1..16.
- p_seq_num_bits, 5, sequence-number width.
- p_window_cycles, 8, maximum squash-window lifetime in cycles; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arb_seq_num  in  p_num_arb*p_seq_num_bits  per-channel squash seq num; channel i occupies bits [i*p_seq_num_bits +: p_seq_num_bits].
- arb_target  in  p_num_arb*32  per-channel redirect PC; channel i occupies [i*32 +: 32].
- arb_val  in  p_num_arb  per-channel valid.
- commit_seq_num  in  p_seq_num_bits  seq num of the committing instruction.
- commit_val  in  1  commit valid.
- gnt_seq_num  out  p_seq_num_bits  issued squash seq num.
- gnt_target  out  32  issued redirect PC.
- gnt_val  out  1  issued squash valid; single-cycle pulse.

Behaviour:
- Reset is asynchronous, active-low, and may assert at any cycle. On assertion:
  - gnt_val=0, gnt_seq_num=0, gnt_target=0.
  - head=0, win_val=0, win_seq=0, win_cnt=0.
  - Any in-progress window is discarded.
- Age rule:
  - age(x) = (x - head) mod 2^p_seq_num_bits, computed at p_seq_num_bits width.
  - a is older than b iff age(a) < age(b).
- Head tracking: on commit_val, head <= commit_seq_num + 1 (wraps). Age comparisons in a cycle use the registered head, never the same-cycle commit.
- Selection (combinational within the cycle):
  - Candidate = valid channel with the smallest age.
  - Equal ages resolve to the lowest index.
  - No valid channel means no candidate.
- Filter:
  - While win_val=1, drop the candidate if age(cand) >= age(win_seq). This covers both equal and younger seq nums.
  - A candidate strictly older than win_seq passes.
- Issue (1-cycle latency):
  - When a candidate passes the filter, next cycle gnt_val=1 with its seq_num and target.
  - Same edge: win_val<=1, win_seq<=cand seq, win_cnt<=p_window_cycles.
  - gnt_val=0 in every cycle without an issue; gnt_seq_num and gnt_target hold their last values.
- Window state machine, IDLE (win_val=0) and WINDOW (win_val=1):
  - IDLE -> WINDOW on issue.
  - WINDOW -> WINDOW (reload win_seq and win_cnt) on an issue of an older squash.
  - WINDOW -> IDLE when win_cnt reaches 1 and decrements, or when commit_val with commit_seq_num == win_seq.
  - Otherwise, in WINDOW, win_cnt decrements by 1 each cycle.
- Simultaneous events:
  - Issue has priority over window expiry or window-closing commit in the same cycle; the new window is loaded.
  - The filter uses the registered window state, so a younger squash arriving in the same cycle as the window-closing commit is still dropped.
- p_num_arb=1: selection degenerates to channel 0; filter, window and latency unchanged.
- Seq-num wrap: handled purely by the modular age rule. Example: with head=30 and 5 bits, seq 1 is younger than seq 31.

Optional Feature:
- Macro: SQUASH_UNIT_L2_STATS_EN.
- Defined: adds outputs stat_issued [15:0] and stat_filtered [15:0].
  - stat_issued increments once per issue.
  - stat_filtered increments once per cycle in which a candidate existed but was dropped.
  - Both saturate at 16'hFFFF and clear on rst_n.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Two channels, same cycle, head=0: ch0 seq=7 tgt=0x100, ch2 seq=3 tgt=0x200 -> next cycle gnt_val=1, seq=3, tgt=0x200; the cycle after, gnt_val=0.
- After issuing seq=3, cycle 2: ch1 seq=5 -> dropped, gnt_val stays 0; cycle 3: ch1 seq=2 tgt=0x80 -> issued, gnt seq=2; win_seq=2.
- p_window_cycles=8, issue seq=4, then squash seq=6 at cycles +1..+8 -> all dropped; squash seq=6 at cycle +9 -> issued.
- Issue seq=4, commit seq=4 at cycle +2, squash seq=6 at cycle +2 -> dropped; squash seq=6 at cycle +3 -> issued.
- Wrap: commit seq=29 (head=30), then ch0 seq=1 and ch1 seq=31 together -> gnt seq=31.
- rst_n low for one cycle mid-window -> gnt_val=0, window cleared; a squash seq=9 after release is issued with 1-cycle latency. With SQUASH_UNIT_L2_STATS_EN defined, the counters read 1 issued and 0 filtered.
